// File: rtl/icache_fill_controller_pkg.sv
// Shared types and field widths for the instruction-cache fill controller.
package icache_fill_controller_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MEM_READ,
    UPDATE
  } state_t;

  localparam int unsigned OFFSET_BITS   = 4;
  localparam int unsigned WORD_SEL_BITS = 2;
  localparam int unsigned BLOCK_BITS    = 128;
  localparam logic [31:0] NOP_WORD      = 32'h0000_0013;

endpackage

// File: rtl/icache_tag_data_array.sv
// Direct-mapped valid/tag/data storage: combinational read, single write port,
// synchronous active-low clear of all valid bits.
module icache_tag_data_array
  import icache_fill_controller_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 3,
  parameter int unsigned TAG_BITS   = 25
) (
  input  logic                  clock,
  input  logic                  clear_n,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [BLOCK_BITS-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [BLOCK_BITS-1:0] wr_data
);

  localparam int unsigned SETS = 1 << INDEX_BITS;

  logic [SETS-1:0]       valid;
  logic [TAG_BITS-1:0]   tags [SETS];
  logic [BLOCK_BITS-1:0] data [SETS];

  // Clear has priority so a line written on the same edge ends up invalid.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      tags[wr_index] <= wr_tag;
      data[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_data  = data[rd_index];

endmodule

// File: rtl/icache_fill_controller.sv
// Direct-mapped instruction cache front end: hit detection, 4-word block refill
// FSM over a read/busywait memory handshake, invalidate and miss counter.
module icache_fill_controller #(
  parameter int unsigned INDEX_BITS = 3,
  parameter logic [31:0] NOP_WORD   = icache_fill_controller_pkg::NOP_WORD
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [31:0]  address,
  output logic [31:0]  instruction,
  output logic         busywait,
  input  logic         invalidate,
  output logic         mem_read,
  output logic [27:0]  mem_address,
  input  logic [127:0] mem_readdata,
  input  logic         mem_busywait,
  output logic [31:0]  miss_count
);

  import icache_fill_controller_pkg::*;

  localparam int unsigned TAG_BITS = 28 - INDEX_BITS;

  state_t                   state;
  logic                     pending_inval;
  logic [BLOCK_BITS-1:0]    fill_block;
  logic [TAG_BITS-1:0]      req_tag;
  logic [INDEX_BITS-1:0]    req_index;
  logic [WORD_SEL_BITS-1:0] word_sel;
  logic                     line_valid;
  logic [TAG_BITS-1:0]      line_tag;
  logic [BLOCK_BITS-1:0]    line_data;
  logic                     hit;
  logic                     start_fill;
  logic                     fill_write;
  logic                     valid_clear_n;
  logic                     unused_addr_bits;

  assign req_tag          = address[31 -: TAG_BITS];
  assign req_index        = address[OFFSET_BITS +: INDEX_BITS];
  assign word_sel         = address[OFFSET_BITS-WORD_SEL_BITS +: WORD_SEL_BITS];
  assign unused_addr_bits = ^address[1:0];

  // mem_address doubles as the latched {tag, index} of the block being filled.
  icache_tag_data_array #(
    .INDEX_BITS(INDEX_BITS),
    .TAG_BITS  (TAG_BITS)
  ) u_array (
    .clock   (clock),
    .clear_n (valid_clear_n),
    .rd_index(req_index),
    .rd_valid(line_valid),
    .rd_tag  (line_tag),
    .rd_data (line_data),
    .wr_en   (fill_write),
    .wr_index(mem_address[INDEX_BITS-1:0]),
    .wr_tag  (mem_address[27 -: TAG_BITS]),
    .wr_data (fill_block)
  );

  always_comb begin
    hit           = line_valid && (line_tag == req_tag) && (state == IDLE) && !invalidate;
    start_fill    = reset && (state == IDLE) && !hit && !invalidate;
    busywait      = reset && !hit;
    instruction   = hit ? line_data[{word_sel, 5'd0} +: 32] : NOP_WORD;
    fill_write    = (state == UPDATE);
    // An invalidate seen during a refill is deferred to the UPDATE->IDLE edge.
    valid_clear_n = !(!reset
                      || ((state == IDLE) && invalidate)
                      || ((state == UPDATE) && (pending_inval || invalidate)));
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= IDLE;
      mem_read      <= 1'b0;
      mem_address   <= '0;
      miss_count    <= '0;
      pending_inval <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_fill) begin
            mem_read    <= 1'b1;
            mem_address <= {req_tag, req_index};
            miss_count  <= miss_count + 32'd1;
            state       <= MEM_READ;
          end
        end
        MEM_READ: begin
          if (invalidate) begin
            pending_inval <= 1'b1;
          end
          if (!mem_busywait) begin
            fill_block <= mem_readdata;
            mem_read   <= 1'b0;
            state      <= UPDATE;
          end
        end
        UPDATE: begin
          pending_inval <= 1'b0;
          state         <= IDLE;
        end
        default: begin
          mem_read <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_fill_controller.sv
// Self-checking bench for icache_fill_controller against a set-level cache model.
module tb_icache_fill_controller;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [31:0]  address = '0;
  logic [31:0]  instruction;
  logic         busywait;
  logic         invalidate = 1'b0;
  logic         mem_read;
  logic [27:0]  mem_address;
  logic [127:0] mem_readdata = '0;
  logic         mem_busywait = 1'b1;
  logic [31:0]  miss_count;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned lat = 3;
  int unsigned rd_cnt = 0;
  logic        mem_auto = 1'b1;
  logic        prev_rd = 1'b0;
  logic [27:0] refills[$];

  logic        model_valid [8];
  logic [24:0] model_tag [8];
  int unsigned model_misses = 0;

  icache_fill_controller #(
    .INDEX_BITS(3),
    .NOP_WORD  (32'h0000_0013)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .address     (address),
    .instruction (instruction),
    .busywait    (busywait),
    .invalidate  (invalidate),
    .mem_read    (mem_read),
    .mem_address (mem_address),
    .mem_readdata(mem_readdata),
    .mem_busywait(mem_busywait),
    .miss_count  (miss_count)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Memory content: word w of block b is {b,4'h0} + w + 1 (block 0 -> 1,2,3,4).
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[31:4], 4'h0} + 32'(a[3:2]) + 32'd1;
  endfunction

  function automatic logic [127:0] block_of(input logic [27:0] b);
    logic [127:0] blk;
    for (int w = 0; w < 4; w++) blk[w*32 +: 32] = {b, 4'h0} + 32'(w) + 32'd1;
    return blk;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) model_valid[i] = 1'b0;
  endtask

  // Memory answers on the lat-th consecutive cycle of mem_read.
  task automatic mem_step();
    if (!mem_auto) return;
    if (mem_read) begin
      mem_busywait = (rd_cnt != lat - 1);
      mem_readdata = mem_busywait ? {$urandom, $urandom, $urandom, $urandom} : block_of(mem_address);
      rd_cnt++;
    end else begin
      rd_cnt       = 0;
      mem_busywait = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    mem_step();
    if (mem_read && !prev_rd) refills.push_back(mem_address);
    prev_rd = mem_read;
    #1;
  endtask

  task automatic wait_hit(output int unsigned n);
    n = 0;
    while (busywait !== 1'b0 && n < 60) begin
      tick();
      n++;
    end
  endtask

  task automatic fetch(input logic [31:0] a);
    int unsigned n;
    logic        h;
    logic [2:0]  ix;
    ix = a[6:4];
    address = a;
    #1;
    h = model_valid[ix] && (model_tag[ix] == a[31:7]);
    checks++;
    if (busywait !== !h) begin
      errors++;
      $display("FAIL fetch_busywait addr=%h got=%b exp=%b", a, busywait, !h);
    end
    if (!h) begin
      refills.delete();
      wait_hit(n);
      checks++;
      if (n != lat + 2) begin
        errors++;
        $display("FAIL miss_latency addr=%h lat=%0d got=%0d exp=%0d", a, lat, n, lat + 2);
      end
      checks++;
      if (refills.size() != 1 || refills[0] !== a[31:4]) begin
        errors++;
        $display("FAIL refill_addr addr=%h refills=%0d exp_one_at=%h", a, refills.size(), a[31:4]);
      end
      model_misses++;
      model_valid[ix] = 1'b1;
      model_tag[ix]   = a[31:7];
    end
    checks++;
    if (instruction !== word_of(a)) begin
      errors++;
      $display("FAIL fetch_instr addr=%h got=%h exp=%h", a, instruction, word_of(a));
    end
    checks++;
    if (miss_count !== model_misses) begin
      errors++;
      $display("FAIL fetch_miss_count addr=%h got=%0d exp=%0d", a, miss_count, model_misses);
    end
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    address = 32'h0000_0000;
    repeat (3) tick();
    checks++;
    if (busywait !== 1'b0) begin errors++; $display("FAIL reset_busywait got=%b exp=0", busywait); end
    checks++;
    if (mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read got=%b exp=0", mem_read); end
    checks++;
    if (mem_address !== 28'd0) begin errors++; $display("FAIL reset_mem_address got=%h exp=0", mem_address); end
    checks++;
    if (miss_count !== 32'd0) begin errors++; $display("FAIL reset_miss_count got=%0d exp=0", miss_count); end
    reset = 1'b1;
    model_clear();
    model_misses = 0;
  endtask

  task automatic test_first_miss();
    lat = 3;
    fetch(32'h0000_0000);
  endtask

  task automatic test_sequential();
    fetch(32'h0000_0004);
    fetch(32'h0000_0008);
    fetch(32'h0000_000C);
  endtask

  task automatic test_conflict();
    fetch(32'h0000_0080);
    fetch(32'h0000_0000);
    checks++;
    if (miss_count !== 32'd3) begin errors++; $display("FAIL conflict_count got=%0d exp=3", miss_count); end
  endtask

  task automatic test_branch_mid_refill();
    int unsigned n;
    lat = 3;
    address = 32'h0000_0100;
    #1;
    checks++;
    if (busywait !== 1'b1) begin errors++; $display("FAIL branch_miss got=%b exp=1", busywait); end
    refills.delete();
    tick();
    address = 32'h0000_0200;
    wait_hit(n);
    checks++;
    if (busywait !== 1'b0) begin errors++; $display("FAIL branch_done got=%b exp=0", busywait); end
    checks++;
    if (refills.size() != 2 || refills[0] !== 28'h10 || refills[1] !== 28'h20) begin
      errors++;
      $display("FAIL branch_refills count=%0d exp 2 refills at 10 then 20", refills.size());
    end
    model_misses += 2;
    model_valid[0] = 1'b1;
    model_tag[0]   = 25'd4;
    checks++;
    if (instruction !== 32'h0000_0201) begin errors++; $display("FAIL branch_instr got=%h exp=00000201", instruction); end
    checks++;
    if (miss_count !== model_misses) begin errors++; $display("FAIL branch_count got=%0d exp=%0d", miss_count, model_misses); end
    tick();
  endtask

  task automatic test_invalidate_idle();
    fetch(32'h0000_0000);
    address = 32'h0000_0000;
    invalidate = 1'b1;
    #1;
    checks++;
    if (busywait !== 1'b1) begin errors++; $display("FAIL inval_mask got=%b exp=1", busywait); end
    tick();
    invalidate = 1'b0;
    #1;
    checks++;
    if (mem_read !== 1'b0) begin errors++; $display("FAIL inval_no_fill got=%b exp=0", mem_read); end
    model_clear();
    fetch(32'h0000_0000);
  endtask

  task automatic test_invalidate_refill();
    int unsigned n;
    lat = 3;
    address = 32'h0000_0070;
    #1;
    checks++;
    if (busywait !== 1'b1) begin errors++; $display("FAIL inval_refill_miss got=%b exp=1", busywait); end
    refills.delete();
    tick();
    invalidate = 1'b1;
    address = 32'h0000_0000;
    tick();
    invalidate = 1'b0;
    wait_hit(n);
    checks++;
    if (refills.size() != 2 || refills[0] !== 28'h7 || refills[1] !== 28'h0) begin
      errors++;
      $display("FAIL inval_refill_seq count=%0d exp 2 refills at 7 then 0", refills.size());
    end
    model_clear();
    model_misses += 2;
    model_valid[0] = 1'b1;
    model_tag[0]   = 25'd0;
    checks++;
    if (instruction !== 32'h0000_0001) begin errors++; $display("FAIL inval_refill_instr got=%h exp=00000001", instruction); end
    checks++;
    if (miss_count !== model_misses) begin errors++; $display("FAIL inval_refill_count got=%0d exp=%0d", miss_count, model_misses); end
    tick();
  endtask

  task automatic test_reset_mid_refill();
    int unsigned n;
    lat = 3;
    address = 32'h0000_0050;
    #1;
    tick();
    checks++;
    if (mem_read !== 1'b1) begin errors++; $display("FAIL rst_mid_read got=%b exp=1", mem_read); end
    reset = 1'b0;
    tick();
    checks++;
    if (mem_read !== 1'b0) begin errors++; $display("FAIL rst_mid_drop got=%b exp=0", mem_read); end
    checks++;
    if (miss_count !== 32'd0) begin errors++; $display("FAIL rst_mid_count got=%0d exp=0", miss_count); end
    checks++;
    if (busywait !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busywait); end
    model_clear();
    model_misses = 0;
    reset = 1'b1;
    mem_auto = 1'b0;
    mem_busywait = 1'b0;
    mem_readdata = {4{32'hDEAD_BEEF}};
    refills.delete();
    #1;
    checks++;
    if (busywait !== 1'b1) begin errors++; $display("FAIL rst_mid_remiss got=%b exp=1", busywait); end
    tick();
    mem_auto = 1'b1;
    rd_cnt = 0;
    mem_step();
    #1;
    wait_hit(n);
    checks++;
    if (n + 1 != lat + 2) begin errors++; $display("FAIL rst_mid_latency got=%0d exp=%0d", n + 1, lat + 2); end
    checks++;
    if (instruction !== word_of(32'h0000_0050)) begin
      errors++;
      $display("FAIL rst_mid_instr got=%h exp=%h", instruction, word_of(32'h0000_0050));
    end
    model_misses = 1;
    model_valid[5] = 1'b1;
    model_tag[5]   = 25'd0;
    checks++;
    if (miss_count !== 32'd1) begin errors++; $display("FAIL rst_mid_count2 got=%0d exp=1", miss_count); end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 60; i++) begin
      a = {23'd0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'b00};
      lat = $urandom_range(1, 4);
      if ($urandom_range(0, 7) == 0) begin
        invalidate = 1'b1;
        tick();
        invalidate = 1'b0;
        model_clear();
      end
      fetch(a);
    end
  endtask

  initial begin
    test_reset();
    test_first_miss();
    test_sequential();
    test_conflict();
    test_branch_mid_refill();
    test_invalidate_idle();
    test_invalidate_refill();
    test_reset_mid_refill();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
